// File: rtl/serial_mag_compare.sv
// Bit-serial magnitude verdict built from MSB-first 1-bit comparator codes {gt, lt, eq}.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first deciding bit-pair.
module serial_mag_compare #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_valid,
  input  logic [2:0]    y_in,
  output logic          busy,
  output logic          done,
  output logic [2:0]    result,
  output logic          err,
  output logic [CW-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] Y_GT = 3'b100;
  localparam logic [2:0] Y_LT = 3'b010;
  localparam logic [2:0] Y_EQ = 3'b001;

  state_t        state_q, state_d;
  logic          busy_d, done_d, err_d;
  logic [2:0]    result_d;
  logic [CW-1:0] cnt_d;
  logic          decided_q, decided_d;
  logic          gt_q, gt_d;

  logic is_gt, is_lt, is_eq, last_bit, decide;

  assign is_gt    = (y_in == Y_GT);
  assign is_lt    = (y_in == Y_LT);
  assign is_eq    = (y_in == Y_EQ);
  assign last_bit = (bit_cnt == CW'(N - 1));
  assign decide   = bit_valid && !decided_q && (is_gt || is_lt);

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 3'b000;
      err       <= 1'b0;
      bit_cnt   <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      result    <= result_d;
      err       <= err_d;
      bit_cnt   <= cnt_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    result_d  = result;
    err_d     = err;
    cnt_d     = bit_cnt;
    decided_d = decided_q;
    gt_d      = gt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          cnt_d     = '0;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          err_d     = 1'b0;
          result_d  = 3'b000;
        end
      end

      ACCUM: begin
        if (bit_valid) begin
          if (!(is_gt || is_lt || is_eq)) err_d = 1'b1;
          if (decide) begin
            decided_d = 1'b1;
            gt_d      = is_gt;
          end
          if (last_bit) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = bit_cnt + CW'(1);
          end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          // Verdict is final once decided; report count including the deciding bit.
          if (decide) begin
            state_d = DONE;
            cnt_d   = bit_cnt + CW'(1);
          end
`endif
        end
      end

      DONE: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        result_d = decided_q ? (gt_q ? Y_GT : Y_LT) : Y_EQ;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACCUM);
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare: driver pushes arithmetic-model verdicts,
// a negedge monitor pops and compares whenever done is presented.
module tb_serial_mag_compare;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bit_valid = 1'b0;
  logic [2:0]    y_in = 3'b000;
  logic          busy, done, err;
  logic [2:0]    result;
  logic [CW-1:0] bit_cnt;

  serial_mag_compare #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .y_in(y_in),
    .busy(busy), .done(done), .result(result), .err(err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]    result;
    logic          err;
    logic [CW-1:0] cnt;
    int            done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [2:0] code(input logic a, input logic b);
    if (a && !b) return 3'b100;
    if (!a && b) return 3'b010;
    return 3'b001;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 32'(result), 32'(mon_e.result));
        check("err", 32'(err), 32'(mon_e.err));
        check("bit_cnt_at_done", 32'(bit_cnt), 32'(mon_e.cnt));
        check("busy_at_done", 32'(busy), 32'd0);
        check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
      end
    end
  end

  // One comparison: model from integer compare, then stream MSB-first with stalls.
  task automatic run_cmp(input logic [N-1:0] a, input logic [N-1:0] b, input int bad_pos,
                         input int stalls, input bit pre_bv, input bit poke);
    int   first_diff, consumed, start_cyc, stall_left, k;
    exp_t e;
    first_diff = -1;
    for (int i = 0; i < int'(N); i++)
      if (first_diff < 0 && a[N-1-i] != b[N-1-i]) first_diff = i;
    consumed   = (EARLY && first_diff >= 0) ? first_diff + 1 : int'(N);
    e.result   = (a > b) ? 3'b100 : ((a < b) ? 3'b010 : 3'b001);
    e.err      = (bad_pos >= 0) && (bad_pos < consumed);
    e.cnt      = EARLY ? CW'(consumed) : '0;

    @(posedge clk); #1;
    start = 1'b1; bit_valid = pre_bv; y_in = 3'b100;
    @(posedge clk); #1;
    start = 1'b0; bit_valid = 1'b0; start_cyc = cyc;
    check("start_busy", 32'(busy), 32'd1);
    check("start_cnt", 32'(bit_cnt), 32'd0);
    check("start_result_clr", 32'(result), 32'd0);
    check("start_err_clr", 32'(err), 32'd0);

    stall_left = stalls;
    for (int i = 0; i < consumed; i++) begin
      while (stall_left > 0 && (i == consumed - 1 || $urandom_range(0, 1) == 1)) begin
        bit_valid = 1'b0; start = poke; y_in = 3'($urandom);
        @(posedge clk); #1;
        stall_left--;
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_cnt", 32'(bit_cnt), 32'(i));
      end
      bit_valid = 1'b1; start = poke;
      y_in = (i == bad_pos) ? 3'b011 : code(a[N-1-i], b[N-1-i]);
      @(posedge clk); #1;
      if (i < consumed - 1) begin
        check("accum_busy", 32'(busy), 32'd1);
        check("accum_cnt", 32'(bit_cnt), 32'(i + 1));
      end
    end
    bit_valid = 1'b0; start = 1'b0;
    e.done_cyc = start_cyc + consumed + stalls + 1;
    exp_q.push_back(e);

    if (poke) start = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) break;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("result_hold", 32'(result), 32'(e.result));
    check("err_hold", 32'(err), 32'(e.err));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b;
    int bp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(bit_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_busy", 32'(busy), 32'd0);

    run_cmp(8'hA5, 8'hA5, -1, 0, 1'b0, 1'b0);
    run_cmp(8'h80, 8'h7F, -1, 0, 1'b0, 1'b0);
    run_cmp(8'h3C, 8'h3D, -1, 3, 1'b0, 1'b0);
    run_cmp(8'h5A, 8'h5A, 2, 0, 1'b0, 1'b0);
    run_cmp(8'h11, 8'h22, -1, 0, 1'b0, 1'b0);
    run_cmp(8'h5A, 8'h5A, -1, 2, 1'b1, 1'b1);
    run_cmp(8'h01, 8'h00, -1, 1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of an accumulation.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      y_in = (i == 1) ? 3'b011 : 3'b001;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    check("pre_rst_err", 32'(err), 32'd1);
    check("pre_rst_cnt", 32'(bit_cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_cnt", 32'(bit_cnt), 32'd0);
    check("async_rst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);
    run_cmp(8'hC3, 8'hC2, -1, 0, 1'b0, 1'b0);

    // Randomized operands, stalls and corrupted codes on equal bit positions.
    for (int t = 0; t < 24; t++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : N'($urandom);
      bp = -1;
      if ($urandom_range(0, 2) == 0) begin
        bp = int'($urandom_range(0, N - 1));
        if (a[N-1-bp] != b[N-1-bp]) bp = -1;
      end
      run_cmp(a, b, bp, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
